control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that drives every control strobe of the datapath, replacing bench-driven T-state stimulus. It runs the fetch sequence (T0-T2), decodes the IR captured on the datapath, and runs the execute steps for register ALU, unary, mul/div, mfhi/mflo, nop and halt instructions. It sits directly upstream of the datapath, and its outputs connect one-to-one to the datapath control ports.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an undefined opcode enters HALT with illegal=1; 0: an undefined opcode executes as nop.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
ir  in  32  datapath IR contents. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
gpr_in  out  16  one-hot register write enable.
gpr_out  out  16  one-hot register bus drive.
hi_in, hi_out, lo_in, lo_out  out  1 each  HI/LO register strobes.
pc_in, pc_out, inc_pc  out  1 each  PC strobes.
ir_in, y_in, z_in, z_high_out, z_low_out  out  1 each  IR, Y and Z strobes.
mar_in, mdr_in, mdr_out, read  out  1 each  memory interface strobes.
alu_op  out  4  And=0, Or=1, Add=2, Sub=3, Shr=4, Shl=5, Ror=6, Rol=7, Mul=8, Div=9, Neg=10, Not=11.
run  out  1  1 except in HALT.
illegal  out  1  sticky; set on an undefined opcode when HALT_ON_ILLEGAL=1.
instr_count  out  32  number of retired instructions.

Behaviour:
- Moore machine. Outputs decode only the registered state and ir. The datapath captures on the rising edge that ends each state. One state per clock.
- Async reset forces state RST, instr_count=0, illegal=0. All strobes are 0, alu_op=0 and run=1 while in RST. This holds even if reset arrives mid-instruction. RST goes to T0 on the first clock after reset deasserts.
- Any strobe not listed for a state is 0. alu_op is 0 unless listed.
- T0: pc_out, mar_in, inc_pc, z_in, alu_op=Add.
- T1: z_low_out, pc_in, read, mdr_in. Memory is combinational, so data is valid in T1.
- T2: mdr_out, ir_in. The IR is valid from T3 onward.
- 3-operand ALU ops (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
  - T3: gpr_out[rb], y_in.
  - T4: gpr_out[rc], z_in, alu_op per opcode.
  - T5: z_low_out, gpr_in[ra]. Retire, then T0.
- neg 10000 / not 10001:
  - T3: gpr_out[rb], z_in, alu_op=Neg or Not.
  - T4: z_low_out, gpr_in[ra]. Retire, then T0.
- mul 01110 / div 01111:
  - T3: gpr_out[ra], y_in.
  - T4: gpr_out[rb], z_in, alu_op=Mul or Div.
  - T5: z_low_out, lo_in.
  - T6: z_high_out, hi_in. Retire, then T0.
- mfhi 10111: T3: hi_out, gpr_in[ra]. Retire, then T0.
- mflo 11000: T3: lo_out, gpr_in[ra]. Retire, then T0.
- nop 11001: T3 with no strobes. Retire, then T0.
- halt 11010: T3 goes to HALT. Retire counts. HALT: all strobes 0, run=0; held until reset.
- Undefined opcodes (including ld/st/branch/io):
  - HALT_ON_ILLEGAL=1: T3 goes to HALT with illegal set; not counted as retired.
  - HALT_ON_ILLEGAL=0: behaves as nop.
- gpr_in and gpr_out are always one-hot or zero; never more than one bit set. ra=0 still asserts gpr_in[0].
- instr_count increments on the final edge of each retired instruction and wraps 0xFFFFFFFF to 0.
- An unreachable state code recovers to RST on the next clock.

Decomposition:
- Shared package cpu_pkg holds: opcode constants; alu_op constants; the state enum (RST, T0-T6, HALT); IR field position constants.
- One sub-module, reg_select: takes ir plus the internal ra/rb/rc in/out requests and produces the one-hot gpr_in/gpr_out.

Test Plan:
- Reset, then ir loaded with 0x52920000 (or R5,R2,R4):
  - T3: gpr_out=0x0004 with y_in.
  - T4: gpr_out=0x0010, alu_op=1, z_in.
  - T5: gpr_in=0x0020 with z_low_out.
  - instr_count=1, next state T0.
- 0x18918000 (add R1,R2,R3):
  - T3 gpr_out=0x0004; T4 gpr_out=0x0008 with alu_op=2; T5 gpr_in=0x0002.
  - Instruction takes 6 clocks.
- 0x71880000 (mul R3,R1):
  - T3 gpr_out=0x0008; T4 gpr_out=0x0002 with alu_op=8.
  - T5 lo_in with z_low_out; T6 hi_in with z_high_out.
  - Takes 7 clocks.
- 0xD0000000 (halt): run=0 after T3, all strobes 0 for 20 clocks, instr_count unchanged after the halt retires.
- 0xF8000000 with HALT_ON_ILLEGAL=1: illegal=1, run=0, instr_count not incremented. With HALT_ON_ILLEGAL=0: returns to T0 after 4 clocks.
- Reset asserted asynchronously mid-T4:
  - Strobes drop to 0 immediately; instr_count=0.
  - T0 begins one clock after reset deasserts.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU, state and IR field definitions for the control unit
package cpu_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_MFHI,
        CLS_MFLO,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: return CLS_ALU3;
            OP_NEG, OP_NOT:                return CLS_UNARY;
            OP_MUL, OP_DIV:                return CLS_MULDIV;
            OP_MFHI:                       return CLS_MFHI;
            OP_MFLO:                       return CLS_MFLO;
            OP_NOP:                        return CLS_NOP;
            OP_HALT:                       return CLS_HALT;
            default:                       return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] alu3_op(input logic [4:0] opc);
        case (opc)
            OP_OR:   return ALU_OR;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/reg_select.sv
// rtl/reg_select.sv - turns ra/rb/rc register requests into one-hot GPR enables
module reg_select
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        ra_in,
    input  logic        ra_out,
    input  logic        rb_out,
    input  logic        rc_out,
    output logic [15:0] gpr_in,
    output logic [15:0] gpr_out
);

    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       unused_ir_bits;

    assign ra = ir[RA_MSB:RA_LSB];
    assign rb = ir[RB_MSB:RB_LSB];
    assign rc = ir[RC_MSB:RC_LSB];
    assign unused_ir_bits = ^{ir[OPC_MSB:OPC_LSB], ir[RC_LSB-1:0]};

    // Priority chain keeps the bus drive one-hot even if requests overlap.
    always_comb begin
        gpr_in  = '0;
        gpr_out = '0;
        if (ra_in)
            gpr_in[ra] = 1'b1;
        if (ra_out)
            gpr_out[ra] = 1'b1;
        else if (rb_out)
            gpr_out[rb] = 1'b1;
        else if (rc_out)
            gpr_out[rc] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute control unit driving datapath strobes
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    output logic [15:0] gpr_in,
    output logic [15:0] gpr_out,
    output logic        hi_in,
    output logic        hi_out,
    output logic        lo_in,
    output logic        lo_out,
    output logic        pc_in,
    output logic        pc_out,
    output logic        inc_pc,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        z_high_out,
    output logic        z_low_out,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        read,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic [31:0] instr_count
);

    state_t     state;
    state_t     state_next;
    op_class_t  cls;
    logic [4:0] opcode;
    logic       retire;
    logic       set_illegal;
    logic       ra_in_req;
    logic       ra_out_req;
    logic       rb_out_req;
    logic       rc_out_req;

    assign opcode = ir[OPC_MSB:OPC_LSB];

    // Without halt-on-illegal, undefined opcodes fall through the nop path.
    always_comb begin
        cls = classify(opcode);
        if (cls == CLS_ILLEGAL && HALT_ON_ILLEGAL == 0)
            cls = CLS_NOP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RST;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            state <= state_next;
            if (retire)
                instr_count <= instr_count + 32'd1;
            if (set_illegal)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next  = ST_RST;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            ST_RST: state_next = ST_T0;
            ST_T0:  state_next = ST_T1;
            ST_T1:  state_next = ST_T2;
            ST_T2:  state_next = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_ALU3, CLS_UNARY, CLS_MULDIV: state_next = ST_T4;
                    CLS_HALT: begin
                        state_next = ST_HALT;
                        retire     = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        state_next  = ST_HALT;
                        set_illegal = 1'b1;
                    end
                    default: begin
                        state_next = ST_T0;
                        retire     = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                if (cls == CLS_UNARY) begin
                    state_next = ST_T0;
                    retire     = 1'b1;
                end else begin
                    state_next = ST_T5;
                end
            end
            ST_T5: begin
                if (cls == CLS_MULDIV) begin
                    state_next = ST_T6;
                end else begin
                    state_next = ST_T0;
                    retire     = 1'b1;
                end
            end
            ST_T6: begin
                state_next = ST_T0;
                retire     = 1'b1;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    always_comb begin
        hi_in = 1'b0; hi_out = 1'b0; lo_in = 1'b0; lo_out = 1'b0;
        pc_in = 1'b0; pc_out = 1'b0; inc_pc = 1'b0; ir_in = 1'b0;
        y_in = 1'b0; z_in = 1'b0; z_high_out = 1'b0; z_low_out = 1'b0;
        mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0;
        alu_op = ALU_AND;
        run = 1'b1;
        ra_in_req = 1'b0; ra_out_req = 1'b0; rb_out_req = 1'b0; rc_out_req = 1'b0;
        case (state)
            ST_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
                alu_op = ALU_ADD;
            end
            ST_T1: begin
                z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            ST_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU3:   begin rb_out_req = 1'b1; y_in = 1'b1; end
                    CLS_UNARY: begin
                        rb_out_req = 1'b1; z_in = 1'b1;
                        alu_op = (opcode == OP_NEG) ? ALU_NEG : ALU_NOT;
                    end
                    CLS_MULDIV: begin ra_out_req = 1'b1; y_in = 1'b1; end
                    CLS_MFHI:   begin hi_out = 1'b1; ra_in_req = 1'b1; end
                    CLS_MFLO:   begin lo_out = 1'b1; ra_in_req = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU3: begin
                        rc_out_req = 1'b1; z_in = 1'b1; alu_op = alu3_op(opcode);
                    end
                    CLS_UNARY: begin z_low_out = 1'b1; ra_in_req = 1'b1; end
                    CLS_MULDIV: begin
                        rb_out_req = 1'b1; z_in = 1'b1;
                        alu_op = (opcode == OP_MUL) ? ALU_MUL : ALU_DIV;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU3:   begin z_low_out = 1'b1; ra_in_req = 1'b1; end
                    CLS_MULDIV: begin z_low_out = 1'b1; lo_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                z_high_out = 1'b1; hi_in = 1'b1;
            end
            ST_HALT: run = 1'b0;
            default: ;
        endcase
    end

    reg_select u_reg_select (
        .ir      (ir),
        .ra_in   (ra_in_req),
        .ra_out  (ra_out_req),
        .rb_out  (rb_out_req),
        .rc_out  (rc_out_req),
        .gpr_in  (gpr_in),
        .gpr_out (gpr_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    localparam logic [15:0] HI_IN = 16'h8000, HI_OUT = 16'h4000, LO_IN = 16'h2000, LO_OUT = 16'h1000;
    localparam logic [15:0] PC_IN = 16'h0800, PC_OUT = 16'h0400, INC_PC = 16'h0200, IR_IN = 16'h0100;
    localparam logic [15:0] Y_IN = 16'h0080, Z_IN = 16'h0040, Z_HIGH_OUT = 16'h0020, Z_LOW_OUT = 16'h0010;
    localparam logic [15:0] MAR_IN = 16'h0008, MDR_IN = 16'h0004, MDR_OUT = 16'h0002, READ = 16'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic [31:0] ir0;

    logic [15:0] gpr_in, gpr_out;
    logic hi_in, hi_out, lo_in, lo_out, pc_in, pc_out, inc_pc, ir_in;
    logic y_in, z_in, z_high_out, z_low_out, mar_in, mdr_in, mdr_out, read;
    logic [3:0]  alu_op;
    logic        run, illegal;
    logic [31:0] instr_count;

    logic [15:0] n_gpr_in, n_gpr_out;
    logic n_hi_in, n_hi_out, n_lo_in, n_lo_out, n_pc_in, n_pc_out, n_inc_pc, n_ir_in;
    logic n_y_in, n_z_in, n_z_high_out, n_z_low_out, n_mar_in, n_mdr_in, n_mdr_out, n_read;
    logic [3:0]  n_alu_op;
    logic        n_run, n_illegal;
    logic [31:0] n_instr_count;

    logic [53:0] obs, n_obs;

    typedef struct {
        string       tag;
        logic [53:0] bits;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    assign obs = {gpr_in, gpr_out,
                  hi_in, hi_out, lo_in, lo_out, pc_in, pc_out, inc_pc, ir_in,
                  y_in, z_in, z_high_out, z_low_out, mar_in, mdr_in, mdr_out, read,
                  alu_op, run, illegal};
    assign n_obs = {n_gpr_in, n_gpr_out,
                    n_hi_in, n_hi_out, n_lo_in, n_lo_out, n_pc_in, n_pc_out, n_inc_pc, n_ir_in,
                    n_y_in, n_z_in, n_z_high_out, n_z_low_out, n_mar_in, n_mdr_in, n_mdr_out, n_read,
                    n_alu_op, n_run, n_illegal};

    control_sequencer #(.HALT_ON_ILLEGAL(1)) dut (
        .clk(clk), .reset(reset), .ir(ir),
        .gpr_in(gpr_in), .gpr_out(gpr_out),
        .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
        .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc),
        .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .z_high_out(z_high_out), .z_low_out(z_low_out),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read),
        .alu_op(alu_op), .run(run), .illegal(illegal), .instr_count(instr_count)
    );

    control_sequencer #(.HALT_ON_ILLEGAL(0)) dut_nop (
        .clk(clk), .reset(reset), .ir(ir0),
        .gpr_in(n_gpr_in), .gpr_out(n_gpr_out),
        .hi_in(n_hi_in), .hi_out(n_hi_out), .lo_in(n_lo_in), .lo_out(n_lo_out),
        .pc_in(n_pc_in), .pc_out(n_pc_out), .inc_pc(n_inc_pc),
        .ir_in(n_ir_in), .y_in(n_y_in), .z_in(n_z_in), .z_high_out(n_z_high_out), .z_low_out(n_z_low_out),
        .mar_in(n_mar_in), .mdr_in(n_mdr_in), .mdr_out(n_mdr_out), .read(n_read),
        .alu_op(n_alu_op), .run(n_run), .illegal(n_illegal), .instr_count(n_instr_count)
    );

    task automatic push(input bit alt, input string tag, input logic [15:0] gi, input logic [15:0] go,
                        input logic [15:0] st, input logic [3:0] op, input logic rn, input logic il,
                        input logic [31:0] cnt);
        exp_t e;
        e.tag  = tag;
        e.bits = {gi, go, st, op, rn, il};
        e.cnt  = cnt;
        if (alt) q0.push_back(e);
        else     q.push_back(e);
    endtask

    task automatic push_fetch(input bit alt, input string tag, input logic [31:0] cnt);
        push(alt, {tag, "_t0"}, 16'h0, 16'h0, PC_OUT | MAR_IN | INC_PC | Z_IN, 4'd2, 1'b1, 1'b0, cnt);
        push(alt, {tag, "_t1"}, 16'h0, 16'h0, Z_LOW_OUT | PC_IN | READ | MDR_IN, 4'd0, 1'b1, 1'b0, cnt);
        push(alt, {tag, "_t2"}, 16'h0, 16'h0, MDR_OUT | IR_IN, 4'd0, 1'b1, 1'b0, cnt);
    endtask

    task automatic check_now();
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed=empty expected=entry");
        end else begin
            e = q.pop_front();
            assert (obs === e.bits) else begin
                errors++;
                $error("FAIL %s strobes: observed=%h expected=%h", e.tag, obs, e.bits);
            end
            checks++;
            assert (instr_count === e.cnt) else begin
                errors++;
                $error("FAIL %s instr_count: observed=%0d expected=%0d", e.tag, instr_count, e.cnt);
            end
        end
        if (q0.size() != 0) begin
            e = q0.pop_front();
            checks++;
            assert (n_obs === e.bits) else begin
                errors++;
                $error("FAIL %s strobes: observed=%h expected=%h", e.tag, n_obs, e.bits);
            end
            checks++;
            assert (n_instr_count === e.cnt) else begin
                errors++;
                $error("FAIL %s instr_count: observed=%0d expected=%0d", e.tag, n_instr_count, e.cnt);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_now();
    endtask

    // IR changes only after T0 is checked, mirroring when the datapath would load it.
    task automatic run_instr(input logic [31:0] instr, input int n);
        step();
        ir = instr;
        for (int i = 1; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ir    = 32'h0;
        ir0   = 32'hF800_0000;

        push(0, "reset", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        step();
        reset = 1'b0;

        push_fetch(0, "or", 32'd0);
        push(0, "or_t3", 16'h0000, 16'h0004, Y_IN, 4'd0, 1'b1, 1'b0, 32'd0);
        push(0, "or_t4", 16'h0000, 16'h0010, Z_IN, 4'd1, 1'b1, 1'b0, 32'd0);
        push(0, "or_t5", 16'h0020, 16'h0000, Z_LOW_OUT, 4'd0, 1'b1, 1'b0, 32'd0);
        run_instr(32'h5292_0000, 6);

        push_fetch(0, "add", 32'd1);
        push(0, "add_t3", 16'h0000, 16'h0004, Y_IN, 4'd0, 1'b1, 1'b0, 32'd1);
        push(0, "add_t4", 16'h0000, 16'h0008, Z_IN, 4'd2, 1'b1, 1'b0, 32'd1);
        push(0, "add_t5", 16'h0002, 16'h0000, Z_LOW_OUT, 4'd0, 1'b1, 1'b0, 32'd1);
        run_instr(32'h1891_8000, 6);

        push_fetch(0, "mul", 32'd2);
        push(0, "mul_t3", 16'h0000, 16'h0008, Y_IN, 4'd0, 1'b1, 1'b0, 32'd2);
        push(0, "mul_t4", 16'h0000, 16'h0002, Z_IN, 4'd8, 1'b1, 1'b0, 32'd2);
        push(0, "mul_t5", 16'h0000, 16'h0000, LO_IN | Z_LOW_OUT, 4'd0, 1'b1, 1'b0, 32'd2);
        push(0, "mul_t6", 16'h0000, 16'h0000, HI_IN | Z_HIGH_OUT, 4'd0, 1'b1, 1'b0, 32'd2);
        run_instr(32'h7188_0000, 7);

        push_fetch(0, "add2", 32'd3);
        push(0, "add2_t3", 16'h0000, 16'h0004, Y_IN, 4'd0, 1'b1, 1'b0, 32'd3);
        push(0, "add2_t4", 16'h0000, 16'h0008, Z_IN, 4'd2, 1'b1, 1'b0, 32'd3);
        run_instr(32'h1891_8000, 5);
        #1 reset = 1'b1;
        #1;
        push(0, "async_reset", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        check_now();
        push(0, "reset_hold", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        step();
        reset = 1'b0;

        push_fetch(0, "nop", 32'd0);
        push(0, "nop_t3", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        run_instr(32'hC800_0000, 4);

        push_fetch(0, "mfhi", 32'd1);
        push(0, "mfhi_t3", 16'h0080, 16'h0000, HI_OUT, 4'd0, 1'b1, 1'b0, 32'd1);
        run_instr(32'hBB80_0000, 4);

        push_fetch(0, "mflo", 32'd2);
        push(0, "mflo_t3", 16'h0001, 16'h0000, LO_OUT, 4'd0, 1'b1, 1'b0, 32'd2);
        run_instr(32'hC000_0000, 4);

        push_fetch(0, "neg", 32'd3);
        push(0, "neg_t3", 16'h0000, 16'h0200, Z_IN, 4'd10, 1'b1, 1'b0, 32'd3);
        push(0, "neg_t4", 16'h0040, 16'h0000, Z_LOW_OUT, 4'd0, 1'b1, 1'b0, 32'd3);
        run_instr(32'h8348_0000, 5);

        push_fetch(0, "not", 32'd4);
        push(0, "not_t3", 16'h0000, 16'h0001, Z_IN, 4'd11, 1'b1, 1'b0, 32'd4);
        push(0, "not_t4", 16'h8000, 16'h0000, Z_LOW_OUT, 4'd0, 1'b1, 1'b0, 32'd4);
        run_instr(32'h8F80_0000, 5);

        push_fetch(0, "halt", 32'd5);
        push(0, "halt_t3", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd5);
        for (int i = 0; i < 20; i++)
            push(0, "halted", 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 32'd6);
        run_instr(32'hD000_0000, 24);

        #1 reset = 1'b1;
        #1;
        push(0, "reset_from_halt", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        check_now();
        push(0, "reset_hold2", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        push(1, "nop_mode_reset", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        step();
        reset = 1'b0;

        push_fetch(0, "ill", 32'd0);
        push(0, "ill_t3", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++)
            push(0, "ill_halted", 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1, 32'd0);
        push_fetch(1, "ill_as_nop_a", 32'd0);
        push(1, "ill_as_nop_a_t3", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd0);
        push_fetch(1, "ill_as_nop_b", 32'd1);
        push(1, "ill_as_nop_b_t3", 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 32'd1);
        push(1, "ill_as_nop_c_t0", 16'h0, 16'h0, PC_OUT | MAR_IN | INC_PC | Z_IN, 4'd2, 1'b1, 1'b0, 32'd2);
        run_instr(32'hF800_0000, 9);

        checks++;
        assert (q.size() + q0.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", q.size() + q0.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
